// File: rtl/pi_rx_if.sv
// Bundle of Pi serial lines, FIFO read port and status flags for pi_rx.
// slave is the receiver side; master is the Pi/consumer side.
interface pi_rx_if #(
  parameter int FIFO_DEPTH = 16
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic             pi_clk;
  logic             pi_frame;
  logic             pi_mosi;
  logic             rd_en;
  logic             err_clr;
  logic [7:0]       rd_data;
  logic             empty;
  logic             full;
  logic [LVL_W-1:0] level;
  logic             frame_done;
  logic             frame_err;
  logic             overrun;
  logic             parity_err;

  modport master (
    output pi_clk, pi_frame, pi_mosi, rd_en, err_clr,
    input  rd_data, empty, full, level, frame_done, frame_err, overrun, parity_err
  );

  modport slave (
    input  pi_clk, pi_frame, pi_mosi, rd_en, err_clr,
    output rd_data, empty, full, level, frame_done, frame_err, overrun, parity_err
  );
endinterface

// File: rtl/pi_rx.sv
// Pi-to-FPGA serial receiver: oversampled MSB-first shifter feeding a FWFT byte FIFO.
// Define PI_RX_PARITY_EN to expect a trailing even-parity bit after every byte.
module pi_rx #(
  parameter int FIFO_DEPTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input logic    osc_clk,
  input logic    reset,
  pi_rx_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;

  state_t                 state, state_n;
  logic [SYNC_STAGES-1:0] clk_pipe, frame_pipe, mosi_pipe;
  logic                   sync_clk, sync_frame, sync_mosi, dly_clk, rise;
  logic [2:0]             cnt, cnt_n;
  logic [7:0]             sr, sr_n;
  logic                   commit, commit_p1, done_set, ferr_set;
  logic [7:0]             mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr, rd_ptr;
  logic [LVL_W-1:0]       level, level_n;
  logic                   full, empty, wr, rd;
  logic                   frame_done, frame_err, overrun;
`ifdef PI_RX_PARITY_EN
  logic                   perr_set, parity_flag;
`endif

  // Stage 0: synchronizers and edge-detect delay
  always_ff @(posedge osc_clk) begin
    clk_pipe   <= {clk_pipe[SYNC_STAGES-2:0], bus.pi_clk};
    frame_pipe <= {frame_pipe[SYNC_STAGES-2:0], bus.pi_frame};
    mosi_pipe  <= {mosi_pipe[SYNC_STAGES-2:0], bus.pi_mosi};
    dly_clk    <= sync_clk;
  end

  assign sync_clk   = clk_pipe[SYNC_STAGES-1];
  assign sync_frame = frame_pipe[SYNC_STAGES-1];
  assign sync_mosi  = mosi_pipe[SYNC_STAGES-1];
  assign rise       = sync_clk & ~dly_clk;

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    sr_n     = sr;
    commit   = 1'b0;
    done_set = 1'b0;
    ferr_set = 1'b0;
`ifdef PI_RX_PARITY_EN
    perr_set = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (sync_frame) begin
          state_n = SHIFT;
          cnt_n   = 3'd0;
        end
      end
      SHIFT: begin
        if (!sync_frame) begin
          state_n = IDLE;
          cnt_n   = 3'd0;
          if (cnt == 3'd0) done_set = 1'b1;
          else             ferr_set = 1'b1;
        end else if (rise) begin
          sr_n  = {sr[6:0], sync_mosi};
          cnt_n = cnt + 3'd1;
          if (cnt == 3'd7) begin
`ifdef PI_RX_PARITY_EN
            state_n = PAR;
`else
            commit  = 1'b1;
`endif
          end
        end
      end
`ifdef PI_RX_PARITY_EN
      PAR: begin
        // A frame closing between byte and parity bit is a truncated byte.
        if (!sync_frame) begin
          state_n  = IDLE;
          ferr_set = 1'b1;
        end else if (rise) begin
          state_n = SHIFT;
          if (^{sr, sync_mosi}) perr_set = 1'b1;
          else                  commit   = 1'b1;
        end
      end
`endif
      default: state_n = IDLE;
    endcase
  end

  assign wr      = commit_p1 & (~full | bus.rd_en);
  assign rd      = bus.rd_en & ~empty;
  assign level_n = level + LVL_W'(wr) - LVL_W'(rd);

  // Stage 1: FSM state, FIFO pointers/level and sticky flags
  always_ff @(posedge osc_clk) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= 3'd0;
      commit_p1  <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      full       <= 1'b0;
      empty      <= 1'b1;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      commit_p1  <= commit;
      wr_ptr     <= wr_ptr + PTR_W'(wr);
      rd_ptr     <= rd_ptr + PTR_W'(rd);
      level      <= level_n;
      full       <= (level_n == LVL_W'(FIFO_DEPTH));
      empty      <= (level_n == '0);
      frame_done <= done_set;
      frame_err  <= (frame_err & ~bus.err_clr) | ferr_set;
      overrun    <= (overrun & ~bus.err_clr) | (commit_p1 & full & ~bus.rd_en);
    end
  end

  always_ff @(posedge osc_clk) begin
    sr <= sr_n;
    if (wr) mem[wr_ptr] <= sr;
  end

`ifdef PI_RX_PARITY_EN
  always_ff @(posedge osc_clk) begin
    if (!reset) parity_flag <= 1'b0;
    else        parity_flag <= (parity_flag & ~bus.err_clr) | perr_set;
  end
  assign bus.parity_err = parity_flag;
`else
  assign bus.parity_err = 1'b0;
`endif

  assign bus.rd_data    = mem[rd_ptr];
  assign bus.empty      = empty;
  assign bus.full       = full;
  assign bus.level      = level;
  assign bus.frame_done = frame_done;
  assign bus.frame_err  = frame_err;
  assign bus.overrun    = overrun;
endmodule

// File: tb/tb_pi_rx.sv
// Scoreboard bench for pi_rx: Pi frames are bit-banged at osc_clk/8 and bytes read back.
module tb_pi_rx;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   done_cnt = 0;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  pi_rx_if #(.FIFO_DEPTH(DEPTH)) bus ();

  pi_rx #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
    .osc_clk (clk),
    .reset   (reset),
    .bus     (bus)
  );

  always @(negedge clk) if (bus.frame_done === 1'b1) done_cnt++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One bit at osc_clk/8; with pop, rd_en coincides with the FIFO write of this bit's commit.
  task automatic send_bit(input logic b, input bit pop);
    logic [7:0] e;
    bus.pi_mosi = b;
    bus.pi_clk  = 1'b0;
    repeat (4) tick();
    bus.pi_clk = 1'b1;
    if (pop) begin
      repeat (3) tick();
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL pop_at_commit: scoreboard empty, required a queued byte");
      end else begin
        e = exp_q.pop_front();
        if (bus.rd_data !== e) begin
          n_fail++;
          $display("FAIL pop_at_commit: rd_data=%h required %h", bus.rd_data, e);
        end
      end
      bus.rd_en = 1'b1;
      tick();
      bus.rd_en = 1'b0;
    end else begin
      repeat (4) tick();
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit pop, input bit bad_par);
    for (int i = 7; i >= 0; i--) begin
`ifdef PI_RX_PARITY_EN
      send_bit(b[i], 1'b0);
`else
      send_bit(b[i], pop && (i == 0));
`endif
    end
`ifdef PI_RX_PARITY_EN
    send_bit((^b) ^ bad_par, pop);
`endif
    if (!bad_par && (exp_q.size() < DEPTH)) exp_q.push_back(b);
  endtask

  task automatic start_frame();
    bus.pi_clk   = 1'b0;
    bus.pi_frame = 1'b1;
    repeat (4) tick();
  endtask

  task automatic end_frame();
    bus.pi_clk   = 1'b0;
    bus.pi_frame = 1'b0;
    repeat (6) tick();
  endtask

  task automatic clear_flags();
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
  endtask

  task automatic read_back(input int n, input string tag);
    logic [7:0] e;
    for (int i = 0; i < n; i++) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL %s: scoreboard empty at read %0d, required a queued byte", tag, i);
      end else begin
        e = exp_q.pop_front();
        if (bus.empty !== 1'b0 || bus.rd_data !== e) begin
          n_fail++;
          $display("FAIL %s[%0d]: rd_data=%h empty=%b required %h empty=0", tag, i, bus.rd_data, bus.empty, e);
        end
      end
      bus.rd_en = 1'b1;
      tick();
      bus.rd_en = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.pi_clk   = i[0];
      bus.pi_frame = ~i[0];
      bus.pi_mosi  = i[1];
      tick();
    end
    bus.pi_clk = 1'b0; bus.pi_frame = 1'b0; bus.pi_mosi = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    repeat (4) tick();
    n_tests++;
    if (bus.empty !== 1'b1 || bus.full !== 1'b0 || bus.level !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_fifo: empty=%b full=%b level=%0d required 1 0 0", bus.empty, bus.full, bus.level);
    end
    n_tests++;
    if (bus.frame_err !== 1'b0 || bus.overrun !== 1'b0 || bus.parity_err !== 1'b0 || done_cnt != 0) begin
      n_fail++;
      $display("FAIL reset_flags: ferr=%b ovr=%b perr=%b done=%0d required all 0",
               bus.frame_err, bus.overrun, bus.parity_err, done_cnt);
    end
  endtask

  task automatic test_two_bytes();
    int d0 = done_cnt;
    start_frame();
    send_byte(8'hA5, 1'b0, 1'b0);
    send_byte(8'h3C, 1'b0, 1'b0);
    end_frame();
    n_tests++;
    if (bus.level !== 5'd2) begin
      n_fail++;
      $display("FAIL two_level: level=%0d required 2", bus.level);
    end
    n_tests++;
    if (done_cnt - d0 != 1) begin
      n_fail++;
      $display("FAIL two_done: frame_done pulses=%0d required 1", done_cnt - d0);
    end
    n_tests++;
    if (bus.frame_err !== 1'b0 || bus.overrun !== 1'b0 || bus.parity_err !== 1'b0) begin
      n_fail++;
      $display("FAIL two_flags: ferr=%b ovr=%b perr=%b required 0", bus.frame_err, bus.overrun, bus.parity_err);
    end
    read_back(2, "two_data");
  endtask

  task automatic test_frame_err();
    int d0 = done_cnt;
    start_frame();
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
    end_frame();
    n_tests++;
    if (bus.frame_err !== 1'b1 || bus.level !== 5'd0 || done_cnt != d0) begin
      n_fail++;
      $display("FAIL ferr_partial: ferr=%b level=%0d done=%0d required 1 0 0", bus.frame_err, bus.level, done_cnt - d0);
    end
    start_frame();
    send_byte(8'h81, 1'b0, 1'b0);
    end_frame();
    n_tests++;
    if (bus.level !== 5'd1) begin
      n_fail++;
      $display("FAIL ferr_next_level: level=%0d required 1", bus.level);
    end
    read_back(1, "ferr_next_data");
    clear_flags();
    n_tests++;
    if (bus.frame_err !== 1'b0) begin
      n_fail++;
      $display("FAIL ferr_clear: ferr=%b required 0", bus.frame_err);
    end
  endtask

  task automatic test_overrun();
    start_frame();
    for (int i = 0; i < 17; i++) send_byte(8'(i), 1'b0, 1'b0);
    end_frame();
    n_tests++;
    if (bus.full !== 1'b1 || bus.level !== 5'd16 || bus.overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL ovr_drop: full=%b level=%0d ovr=%b required 1 16 1", bus.full, bus.level, bus.overrun);
    end
    read_back(16, "ovr_data");
    clear_flags();
    n_tests++;
    if (bus.overrun !== 1'b0 || bus.empty !== 1'b1) begin
      n_fail++;
      $display("FAIL ovr_clear: ovr=%b empty=%b required 0 1", bus.overrun, bus.empty);
    end
    start_frame();
    for (int i = 0; i < 17; i++) send_byte(8'(i), i == 16, 1'b0);
    end_frame();
    n_tests++;
    if (bus.full !== 1'b1 || bus.level !== 5'd16 || bus.overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_pop: full=%b level=%0d ovr=%b required 1 16 0", bus.full, bus.level, bus.overrun);
    end
    read_back(16, "ovr_pop_data");
  endtask

  task automatic test_reset_mid();
    start_frame();
    for (int i = 0; i < 3; i++) send_byte(8'hC0 + 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(i[0], 1'b0);
    reset = 1'b0;
    bus.pi_clk = 1'b0; bus.pi_frame = 1'b0; bus.pi_mosi = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    exp_q.delete();
    repeat (3) tick();
    n_tests++;
    if (bus.level !== 5'd0 || bus.empty !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid: level=%0d empty=%b required 0 1", bus.level, bus.empty);
    end
    start_frame();
    send_byte(8'h7E, 1'b0, 1'b0);
    end_frame();
    n_tests++;
    if (bus.level !== 5'd1) begin
      n_fail++;
      $display("FAIL rst_mid_level: level=%0d required 1", bus.level);
    end
    read_back(1, "rst_mid_data");
  endtask

  task automatic test_parity();
`ifdef PI_RX_PARITY_EN
    start_frame();
    send_byte(8'h01, 1'b0, 1'b0);
    send_byte(8'h01, 1'b0, 1'b1);
    end_frame();
    n_tests++;
    if (bus.level !== 5'd1 || bus.parity_err !== 1'b1) begin
      n_fail++;
      $display("FAIL parity: level=%0d perr=%b required 1 1", bus.level, bus.parity_err);
    end
    read_back(1, "parity_data");
    clear_flags();
    n_tests++;
    if (bus.parity_err !== 1'b0) begin
      n_fail++;
      $display("FAIL parity_clear: perr=%b required 0", bus.parity_err);
    end
`else
    n_tests++;
    if (bus.parity_err !== 1'b0) begin
      n_fail++;
      $display("FAIL parity_tied: perr=%b required 0", bus.parity_err);
    end
`endif
  endtask

  initial begin
    bus.pi_clk = 1'b0; bus.pi_frame = 1'b0; bus.pi_mosi = 1'b0;
    bus.rd_en = 1'b0; bus.err_clr = 1'b0;
    test_reset();
    test_two_bytes();
    test_frame_err();
    test_overrun();
    test_reset_mid();
    test_parity();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pi_rx.md
# pi_rx

Serial receiver for the Pi-to-FPGA direction of the Pi link: the Pi drives a clock, a frame flag and a data line, and this block shifts the data in MSB first, eight bits per byte. It runs entirely on `osc_clk`, oversampling the Pi's lines through synchronizers, and buffers received bytes in a small first-word-fall-through FIFO. Downstream control logic reads waveform and configuration bytes from this FIFO.

## Interface
- `FIFO_DEPTH`, 16: FIFO entries; must be a power of 2, ≥2.
- `SYNC_STAGES`, 2: synchronizer flops on `pi_clk`, `pi_frame` and `pi_mosi`; must be ≥2.

- `osc_clk` in 1: single clock for all logic.
- `reset` in 1: synchronous, active-low (asserted at 0).
- `pi_clk` in 1: Pi serial clock, asynchronous; data sampled on its rising edge.
- `pi_frame` in 1: Pi frame flag, high for the whole transfer.
- `pi_mosi` in 1: Pi serial data, MSB first.
- `rd_en` in 1: pop the head byte; ignored when `empty`.
- `err_clr` in 1: clears the sticky flags.
- `rd_data` out 8: head byte, valid while `!empty`.
- `empty` out 1: FIFO empty.
- `full` out 1: FIFO full.
- `level` out clog2(FIFO_DEPTH)+1: bytes stored.
- `frame_done` out 1: one-cycle pulse when a frame closes cleanly.
- `frame_err` out 1: sticky; frame ended mid-byte.
- `overrun` out 1: sticky; a byte was dropped because the FIFO was full.
- `parity_err` out 1: sticky; parity mismatch (see Configuration).

## Operation
- Inputs pass through `SYNC_STAGES` flops plus one delay flop. A rising edge is `sync_clk & ~dly_clk`. The same stage of `pi_mosi` is sampled.
- FSM states:
  - IDLE: waiting. Moves to SHIFT when the synced frame flag is 1; the bit counter clears.
  - SHIFT: each rising edge shifts `{sr[6:0], mosi}` into the shift register and increments the counter 0..7.
    - On the 8th bit, the byte is committed and the FSM stays in SHIFT with the counter at 0, unless PAR is enabled.
    - If the synced frame flag falls with counter = 0, the FSM pulses `frame_done` and returns to IDLE.
    - If it falls with counter ≠ 0, the partial byte is discarded, `frame_err` sets, and the FSM returns to IDLE.
  - PAR: present only with the macro; described under Configuration.
- Commit behaviour:
  - Commit while `!full`: the byte is written at the write pointer.
  - Commit while `full` and `rd_en`: the byte is accepted, `level` is unchanged, and `overrun` is not set.
  - Commit while `full` and `!rd_en`: the byte is dropped and `overrun` sets.
- Pointers are clog2(FIFO_DEPTH) bits wide and wrap naturally. `level` = writes − reads. `full` = (`level` == FIFO_DEPTH); `empty` = (`level` == 0). All three are registered.
- `rd_en` while `empty` has no effect.
- Sticky flags:
  - Cleared only by `err_clr` or reset.
  - A set event in the same cycle as `err_clr` leaves the flag set.
- Reset values: `empty`=1, `full`=0, `level`=0, `frame_done`=0, all flags 0, FSM in IDLE, pointers and counter 0. `rd_data` is don't-care while `empty`.
- Reset in mid-byte or mid-frame discards everything, including FIFO contents. After reset the FSM re-enters SHIFT only when it sees the synced frame flag high.

## Timing
- Pi link requirement: each `pi_clk` high and low phase is ≥ SYNC_STAGES+1 `osc_clk` periods. `pi_mosi` is stable ≥1 period before and after the rising edge.
- Latency, with the `osc_clk` edge that first samples the 8th `pi_clk` high as edge k:
  - The shift occurs at edge k+SYNC_STAGES.
  - The FIFO write occurs at edge k+SYNC_STAGES+1.
  - `empty` falls, and `rd_data` is valid, in the following cycle.
- `rd_data` falls through. After a pop at edge n, the next byte appears on `rd_data` right after edge n.
- `frame_done` is high for exactly the one cycle after the synced frame flag falls.

## Configuration
- `PI_RX_PARITY_EN` defined: each byte is followed by a 9th bit carrying even parity, so the total number of ones including the parity bit is even. After the 8th bit the FSM enters PAR.
  - The next edge checks parity.
  - Match: the byte is committed.
  - Mismatch: the byte is dropped and `parity_err` sets.
  - Either way the FSM returns to SHIFT.
  - Frame falling while in PAR counts as mid-byte: `frame_err` sets.
- Undefined: no PAR state, bytes are 8 bits, and `parity_err` is tied to 0. The port exists in both builds.

## Test plan
- Reset: hold `reset`=0 for 3 cycles with the Pi lines toggling → `empty`=1, `full`=0, `level`=0, all flags 0, no `frame_done`.
- Frame carrying 0xA5, 0x3C with `pi_clk` = `osc_clk`/8 → `level`=2, `rd_data`=0xA5, then 0x3C after one `rd_en`; one `frame_done` pulse; no flags set.
- Frame dropped after 5 bits → nothing written and `frame_err`=1. A following frame carrying 0x81 is received intact. `err_clr` then clears `frame_err`.
- 17 bytes 0x00..0x10 with no reads (depth 16) → `full`=1, `level`=16, `overrun`=1, reads return 0x00..0x0F. Repeat with `rd_en` asserted during the 17th commit → `overrun`=0, `level`=16.
- `reset`=0 after 4 bits of a byte with 3 bytes already queued → `level`=0, `empty`=1. A new frame carrying 0x7E is received correctly.
- `PI_RX_PARITY_EN` build: 0x01 with parity bit 1 → stored; 0x01 with parity bit 0 → dropped, `parity_err`=1, `level` unchanged.
